// File: rtl/generic_mac_array.sv
// generic_mac_array
//   Multi-lane pipelined multiply-accumulate engine. Each lane multiplies its
//   operand pair, registers the product (stage 1), and adds it into a per-lane
//   accumulator (stage 2). After ACC_CYCLES accepted samples the window sums
//   are offered on a valid/ready handshake. The window then restarts
//   automatically. Signed/unsigned arithmetic, optional saturation, sticky
//   per-lane overflow flags and a synchronous clear are supported.
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   clear         synchronous abort: drops window, flushes pipeline
//   in_valid      operand vector valid
//   in_ready      operands are accepted this cycle (ACCUM only)
//   operand_a     lane i at [i*BITWIDTH_A +: BITWIDTH_A]
//   operand_b     lane i at [i*BITWIDTH_B +: BITWIDTH_B]
//   res_valid     acc_result holds a completed window
//   res_ready     consumer takes the result
//   acc_result    per-lane window sums, lane i at [i*BITWIDTH_ACC +: BITWIDTH_ACC]
//   overflow      sticky per-lane overflow for the current window
//   sample_count  samples accepted in the current window
//
// state | meaning
// ------+----------------------------------------------------------
// ACCUM | taking samples; last accept of the window moves to DRAIN
// DRAIN | final product is being added; no input accepted
// DONE  | result presented, held until res_ready

module generic_mac_array #(
  parameter int BITWIDTH_A   = 8,
  parameter int BITWIDTH_B   = 8,
  parameter int LANES        = 4,
  parameter int ACC_CYCLES   = 400,
  parameter int BITWIDTH_ACC = 25,
  parameter int SIGNED       = 0,
  parameter int SATURATE     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*BITWIDTH_A-1:0]        operand_a,
  input  logic [LANES*BITWIDTH_B-1:0]        operand_b,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [LANES*BITWIDTH_ACC-1:0]      acc_result,
  output logic [LANES-1:0]                   overflow,
  output logic [$clog2(ACC_CYCLES+1)-1:0]    sample_count
);

  localparam int PROD_W = BITWIDTH_A + BITWIDTH_B;
  localparam int ACC_W  = BITWIDTH_ACC;
  localparam int CNT_W  = $clog2(ACC_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_CYCLES - 1);
  localparam logic [ACC_W-1:0] SIGNED_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SIGNED_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } macState_t;

  macState_t        state;
  macState_t        stateNext;
  logic             accept;
  logic             lastAccept;
  logic             resTaken;
  logic             prodValid;
  logic [CNT_W-1:0] sampleCnt;

  // clear drops any sample presented alongside it
  assign accept     = in_valid & in_ready & ~clear;
  assign lastAccept = accept & (sampleCnt == LAST_IDX);
  assign resTaken   = res_valid & res_ready;

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (lastAccept) stateNext = DRAIN;
      end
      DRAIN: begin
        stateNext = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) stateNext = ACCUM;
      end
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      prodValid <= 1'b0;
      sampleCnt <= '0;
    end else if (clear) begin
      state     <= ACCUM;
      prodValid <= 1'b0;
      sampleCnt <= '0;
    end else begin
      state     <= stateNext;
      prodValid <= accept;
      if (resTaken)
        sampleCnt <= '0;
      else if (accept)
        sampleCnt <= sampleCnt + CNT_W'(1);
    end
  end

  assign sample_count = sampleCnt;

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [BITWIDTH_A-1:0] aLane;
    logic [BITWIDTH_B-1:0] bLane;
    logic [PROD_W-1:0]     aExt;
    logic [PROD_W-1:0]     bExt;
    logic [PROD_W-1:0]     prodReg;
    logic [ACC_W-1:0]      prodExt;
    logic [ACC_W-1:0]      accReg;
    logic [ACC_W-1:0]      accSum;
    logic [ACC_W-1:0]      accNext;
    logic                  ovfLane;
    logic                  ovfSticky;

    assign aLane = operand_a[i*BITWIDTH_A +: BITWIDTH_A];
    assign bLane = operand_b[i*BITWIDTH_B +: BITWIDTH_B];

    // Operands are extended to the full product width first, so the low
    // PROD_W bits of a plain multiply are correct for both number systems.
    if (SIGNED != 0) begin : gSigned
      assign aExt    = PROD_W'($signed(aLane));
      assign bExt    = PROD_W'($signed(bLane));
      assign prodExt = ACC_W'($signed(prodReg));
      assign accSum  = accReg + prodExt;
      assign ovfLane = (accReg[ACC_W-1] == prodExt[ACC_W-1]) &&
                       (accSum[ACC_W-1] != accReg[ACC_W-1]);
    end else begin : gUnsigned
      logic [ACC_W:0] sumWide;
      assign aExt    = PROD_W'(aLane);
      assign bExt    = PROD_W'(bLane);
      assign prodExt = ACC_W'(prodReg);
      assign sumWide = {1'b0, accReg} + {1'b0, prodExt};
      assign accSum  = sumWide[ACC_W-1:0];
      assign ovfLane = sumWide[ACC_W];
    end

    // Signed overflow only happens when both addends share a sign, so the
    // accumulator's sign tells which rail to clamp to.
    always_comb begin
      accNext = accSum;
      if (ovfLane && (SATURATE != 0)) begin
        if (SIGNED != 0)
          accNext = accReg[ACC_W-1] ? SIGNED_MIN : SIGNED_MAX;
        else
          accNext = '1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prodReg   <= '0;
        accReg    <= '0;
        ovfSticky <= 1'b0;
      end else if (clear || resTaken) begin
        accReg    <= '0;
        ovfSticky <= 1'b0;
      end else begin
        if (accept)
          prodReg <= aExt * bExt;
        if (prodValid) begin
          accReg <= accNext;
          if (ovfLane) ovfSticky <= 1'b1;
        end
      end
    end

    assign acc_result[i*ACC_W +: ACC_W] = accReg;
    assign overflow[i]                  = ovfSticky;
  end

endmodule

// File: tb/tb_generic_mac_array.sv
// Bench for generic_mac_array: four instances (unsigned/signed x saturate/wrap)
// share one stimulus stream; a high-level arithmetic model predicts every
// window and a monitor compares whenever a result is handshaken.
module tb_generic_mac_array;

  localparam int NDUT = 4;
  localparam int ACC  = 4;

  logic clk;
  logic reset;
  logic clear;
  logic inValid;
  logic resReady;
  logic [15:0] opA;
  logic [15:0] opB;

  logic [NDUT-1:0]           inReady;
  logic [NDUT-1:0]           resValid;
  logic [NDUT-1:0][31:0]     accResult;
  logic [NDUT-1:0][1:0]      ovf;
  logic [NDUT-1:0][2:0]      sampleCnt;

  int totalCnt = 0;
  int passCnt  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } smp_t;

  typedef struct {
    logic [NDUT-1:0][31:0] res;
    logic [NDUT-1:0][1:0]  ovf;
  } exp_t;

  smp_t win[$];
  exp_t expQ[$];
  exp_t monExp;

  // instance g: SIGNED = g/2, SATURATE = 1 for even g
  for (genvar g = 0; g < NDUT; g++) begin : gDut
    generic_mac_array #(
      .BITWIDTH_A(8), .BITWIDTH_B(8), .LANES(2), .ACC_CYCLES(ACC),
      .BITWIDTH_ACC(16), .SIGNED(g / 2), .SATURATE(1 - (g % 2))
    ) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(inValid), .in_ready(inReady[g]),
      .operand_a(opA), .operand_b(opB),
      .res_valid(resValid[g]), .res_ready(resReady),
      .acc_result(accResult[g]), .overflow(ovf[g]),
      .sample_count(sampleCnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Window sums by integer arithmetic with explicit range bounds.
  function automatic exp_t predict();
    exp_t   e;
    longint s, lo, hi, av, bv;
    logic   o;
    logic [7:0] ab, bb;
    for (int g = 0; g < NDUT; g++) begin
      for (int l = 0; l < 2; l++) begin
        s  = 0;
        o  = 1'b0;
        lo = (g >= 2) ? -32768 : 0;
        hi = (g >= 2) ? 32767 : 65535;
        foreach (win[k]) begin
          ab = win[k].a[l*8 +: 8];
          bb = win[k].b[l*8 +: 8];
          if (g >= 2) begin
            av = longint'($signed(ab));
            bv = longint'($signed(bb));
          end else begin
            av = longint'(ab);
            bv = longint'(bb);
          end
          s = s + av * bv;
          if (s > hi) begin
            o = 1'b1;
            s = (g % 2 == 0) ? hi : s - 65536;
          end else if (s < lo) begin
            o = 1'b1;
            s = (g % 2 == 0) ? lo : s + 65536;
          end
        end
        e.res[g][l*16 +: 16] = s[15:0];
        e.ovf[g][l]          = o;
      end
    end
    return e;
  endfunction

  // Reference model: records accepted samples, predicts completed windows.
  always @(negedge clk) begin
    if (reset || clear) begin
      win.delete();
      expQ.delete();
    end else if (inValid && inReady[0]) begin
      win.push_back('{a: opA, b: opB});
      if (win.size() == ACC) begin
        expQ.push_back(predict());
        win.delete();
      end
    end
  end

  // Monitor: compares each handshaken result against the oldest prediction.
  always @(negedge clk) begin
    if (!reset && !clear && resReady && (resValid != '0)) begin
      chk("result_expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        for (int g = 0; g < NDUT; g++) begin
          chk($sformatf("valid_dut%0d", g), 64'(resValid[g]), 64'd1);
          chk($sformatf("res_dut%0d", g), 64'(accResult[g]), 64'(monExp.res[g]));
          chk($sformatf("ovf_dut%0d", g), 64'(ovf[g]), 64'(monExp.ovf[g]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b);
    inValid = 1'b1;
    opA = a;
    opB = b;
    tick();
    inValid = 1'b0;
  endtask

  task automatic waitResult(input string nm);
    int n = 0;
    while (!resValid[0] && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 64'(resValid[0]), 64'd1);
  endtask

  task automatic handshake();
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
  endtask

  task automatic chkZero(input string nm);
    chk({nm, "_res_valid"}, 64'(resValid[0]), 64'd0);
    chk({nm, "_acc"}, 64'(accResult[0]), 64'd0);
    chk({nm, "_ovf"}, 64'(ovf[0]), 64'd0);
    chk({nm, "_count"}, 64'(sampleCnt[0]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; inValid = 1'b0; resReady = 1'b0;
    opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    chkZero("reset");
    reset = 1'b0;
    #1;
    chk("reset_in_ready", 64'(inReady[0]), 64'd1);

    // lane0 3*5, lane1 10*20, four back-to-back samples
    for (int k = 0; k < ACC; k++) begin
      chk("t1_in_ready", 64'(inReady[0]), 64'd1);
      feed(16'h0A03, 16'h1405);
    end
    chk("t1_drain_in_ready", 64'(inReady[0]), 64'd0);
    chk("t1_drain_res_valid", 64'(resValid[0]), 64'd0);
    chk("t1_count_full", 64'(sampleCnt[0]), 64'd4);
    tick();
    chk("t1_latency", 64'(resValid[0]), 64'd1);
    chk("t1_result", 64'(accResult[0]), 64'h0320_003C);
    chk("t1_ovf", 64'(ovf[0]), 64'd0);
    chk("t1_done_in_ready", 64'(inReady[0]), 64'd0);
    handshake();

    // gapped input: only valid samples count
    opA = 16'h0A03;
    opB = 16'h1405;
    for (int k = 0; k < ACC; k++) begin
      inValid = 1'b1;
      tick();
      chk("t2_count", 64'(sampleCnt[0]), 64'(k + 1));
      if (k < ACC - 1) begin
        inValid = 1'b0;
        tick();
        chk("t2_count_gap", 64'(sampleCnt[0]), 64'(k + 1));
      end
    end
    inValid = 1'b0;
    waitResult("t2");

    // backpressure in DONE
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", 64'(resValid[0]), 64'd1);
      chk("t3_hold_in_ready", 64'(inReady[0]), 64'd0);
      chk("t3_hold_result", 64'(accResult[0]), 64'h0320_003C);
    end
    handshake();
    chk("t3_after_acc", 64'(accResult[0]), 64'd0);
    chk("t3_after_count", 64'(sampleCnt[0]), 64'd0);
    chk("t3_after_in_ready", 64'(inReady[0]), 64'd1);

    // unsigned overflow: 255*255 x4
    for (int k = 0; k < ACC; k++) feed(16'hFFFF, 16'hFFFF);
    waitResult("t5");
    chk("t5_sat_lane0", 64'(accResult[0][15:0]), 64'd65535);
    chk("t5_sat_ovf", 64'(ovf[0]), 64'd3);
    chk("t5_wrap_lane0", 64'(accResult[1][15:0]), 64'd63492);
    chk("t5_wrap_ovf", 64'(ovf[1]), 64'd3);
    chk("t5_signed_lane0", 64'(accResult[2][15:0]), 64'd4);
    handshake();

    // signed: -128*127 x4
    for (int k = 0; k < ACC; k++) feed(16'h8080, 16'h7F7F);
    waitResult("t6");
    chk("t6_ssat_lane0", 64'(accResult[2][15:0]), 64'h8000);
    chk("t6_ssat_ovf", 64'(ovf[2]), 64'd3);
    chk("t6_swrap_lane0", 64'(accResult[3][15:0]), 64'h0200);
    chk("t6_unsigned_lane0", 64'(accResult[0][15:0]), 64'd65024);
    chk("t6_unsigned_ovf", 64'(ovf[0]), 64'd0);
    handshake();

    // abort mid-window
    feed(16'($urandom), 16'($urandom));
    feed(16'($urandom), 16'($urandom));
    chk("t7_partial_count", 64'(sampleCnt[0]), 64'd2);
    clear = 1'b1;
    inValid = 1'b1;
    tick();
    clear = 1'b0;
    inValid = 1'b0;
    chk("t7_clear_count", 64'(sampleCnt[0]), 64'd0);
    chk("t7_clear_acc", 64'(accResult[0]), 64'd0);
    for (int k = 0; k < ACC; k++) feed(16'h0101, 16'h0101);
    waitResult("t7");
    chk("t7_result", 64'(accResult[0]), 64'h0004_0004);
    handshake();

    // clear and res_ready together in DONE
    for (int k = 0; k < ACC; k++) feed(16'hFFFF, 16'($urandom));
    waitResult("t8");
    clear = 1'b1;
    resReady = 1'b1;
    tick();
    clear = 1'b0;
    resReady = 1'b0;
    chkZero("t8");
    chk("t8_in_ready", 64'(inReady[0]), 64'd1);

    // async reset during DRAIN
    for (int k = 0; k < ACC; k++) feed(16'hFFFF, 16'hFFFF);
    reset = 1'b1;
    #1;
    chkZero("t9");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t9_no_result", 64'(resValid[0]), 64'd0);
    end

    // randomized traffic, backpressure and occasional clears
    for (int c = 0; c < 600; c++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      opA      = 16'($urandom);
      opB      = 16'($urandom);
      resReady = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 49) == 0);
      tick();
    end
    inValid = 1'b0;
    clear = 1'b0;
    resReady = 1'b1;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    resReady = 1'b0;
    tick();
    chk("queue_drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
